bus_master_arbiter: RTL and testbench
=====================================

Name: bus_master_arbiter

Overview:
- Arbitrates the shared system bus between four masters: L2 cache refill/writeback, uncached direct loader, and two spare ports.
- Sits between master-side caches/loaders and the slave-side bus decode/memory devices.
- Serialises single-word read/write transactions: one outstanding transaction at a time.
- Round-robin or fixed priority; watchdog timeout converts missing slave acks into an error completion.

Parameters:
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (master 0 highest, master 3 lowest)
TIMEOUT, 255, max WAIT cycles without slave ack before error completion (1..255)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
master_rreq  input  4  per-master read request, level, held until acc
master_wreq  input  4  per-master write request, level, held until acc
master_addr  input  128  packed addresses, master i at [32*i+:32]
master_wdata  input  128  packed write data, master i at [32*i+:32]
master_acc  output  4  one-cycle completion pulse to granted master
master_rdata  output  32  read data, valid in the master_acc cycle
master_err  output  1  pulses with master_acc when transaction timed out
master_busy  output  1  high whenever state != IDLE
slave_rreq  output  1  one-cycle read strobe to slaves
slave_wreq  output  1  one-cycle write strobe to slaves
slave_addr  output  32  latched address, stable ISSUE through RELEASE
slave_wdata  output  32  latched write data, stable ISSUE through RELEASE
slave_rdata  input  32  read data, sampled when slave_ack high
slave_ack  input  1  transaction complete from addressed slave
timeout_flag  output  1  sticky; set on any timeout, cleared only by reset
timeout_addr  output  32  address of most recent timed-out transaction

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; round-robin pointer last_grant = 3, so master 0 wins first.
  - Timer 0.
  - Reset mid-transaction aborts with no acc pulse.
- States: IDLE, ISSUE, WAIT, RELEASE (2-bit register).
- IDLE:
  - req[i] = master_rreq[i] | master_wreq[i].
  - If any req: select winner, latch index g, addr, wdata and direction, then go to ISSUE.
  - Round-robin search order: last_grant+1, +2, +3, +4, mod 4.
  - Fixed mode: lowest index wins.
  - If master g asserts both rreq and wreq, the write wins; this is illegal but deterministic.
- ISSUE:
  - slave_rreq or slave_wreq high for exactly this cycle.
  - Timer cleared.
  - Go to WAIT.
  - slave_ack is ignored in ISSUE; slaves ack no earlier than the cycle after the strobe.
- WAIT:
  - Timer increments each cycle.
  - On slave_ack: master_rdata <= slave_rdata (reads only; writes leave it unchanged); master_acc[g] pulses next cycle; go to RELEASE.
  - If timer == TIMEOUT-1 and no ack:
    - master_acc[g] and master_err pulse next cycle.
    - master_rdata <= 32'hFFFF_FFFF.
    - timeout_flag <= 1; timeout_addr <= latched addr.
    - Go to RELEASE.
  - If ack and timeout coincide, the ack wins and no error is raised.
- RELEASE:
  - master_acc[g] high for this cycle only.
  - last_grant <= g.
  - All requests ignored.
  - Go to IDLE.
  - Masters drop their request in the cycle after acc; a still-held request in IDLE starts a new transaction.
- Latency:
  - Request sampled at edge N → strobe in cycle N+1.
  - Ack in cycle N+2 at earliest → acc in cycle N+3.
  - Back-to-back throughput: 4 cycles per transaction.
- Only one master_acc bit is ever set. The master_acc and slave strobes are registered outputs.
- Requests arriving in any non-IDLE state wait. No starvation in round-robin mode: worst-case wait is 3 transactions.

Test Plan:
- Master 1 read 0x0000_8004, slave acks one cycle after strobe with 0xDEADBEEF → slave_rreq at N+1, master_acc=4'b0010 at N+3, master_rdata=0xDEADBEEF, master_err=0.
- All four masters request simultaneously and hold through re-requests, PRIORITY_MODE=0 → grant order 0,1,2,3,0; master_acc pulses spaced ≥4 cycles apart.
- Same stimulus with PRIORITY_MODE=1 and master 0 re-requesting continuously → master 0 always wins; masters 1-3 are never acked while master 0 requests.
- Master 2 writes 0x1234_5678 to 0xC000_0000 with no ack and TIMEOUT=255 → master_acc[2] and master_err pulse; master_rdata=0xFFFF_FFFF; timeout_flag=1; timeout_addr=0xC000_0000.
- Reset asserted while in WAIT → all outputs 0 asynchronously; after release, master 0 wins the first arbitration; timeout_flag=0.
- Master 3 asserts rreq and wreq together with wdata 0xA5A5A5A5 → slave_wreq strobed, slave_rreq stays 0, slave_wdata=0xA5A5A5A5.

Source files
------------

// File: rtl/bus_master_arbiter_if.sv
// Bus bundle between the four masters, the arbiter and the slave-side decode.
// Masters hold rreq/wreq (level) until their one-cycle acc pulse; the arbiter issues
// a one-cycle slave_rreq/slave_wreq strobe and waits for slave_ack, no sooner than
// the cycle after the strobe.
interface bus_master_arbiter_if;
  logic [3:0]   master_rreq;
  logic [3:0]   master_wreq;
  logic [127:0] master_addr;
  logic [127:0] master_wdata;
  logic [3:0]   master_acc;
  logic [31:0]  master_rdata;
  logic         master_err;
  logic         master_busy;
  logic         slave_rreq;
  logic         slave_wreq;
  logic [31:0]  slave_addr;
  logic [31:0]  slave_wdata;
  logic [31:0]  slave_rdata;
  logic         slave_ack;
  logic         timeout_flag;
  logic [31:0]  timeout_addr;
  logic [1:0]   state_dbg;

  modport master (
    input  master_rreq, master_wreq, master_addr, master_wdata, slave_rdata, slave_ack,
    output master_acc, master_rdata, master_err, master_busy, slave_rreq, slave_wreq,
           slave_addr, slave_wdata, timeout_flag, timeout_addr, state_dbg
  );

  modport slave (
    output master_rreq, master_wreq, master_addr, master_wdata, slave_rdata, slave_ack,
    input  master_acc, master_rdata, master_err, master_busy, slave_rreq, slave_wreq,
           slave_addr, slave_wdata, timeout_flag, timeout_addr, state_dbg
  );
endinterface

// File: rtl/bus_master_arbiter.sv
// Four-master single-outstanding bus arbiter with round-robin or fixed priority
// and a watchdog that turns a missing slave ack into an error completion.
module bus_master_arbiter #(
  parameter int PRIORITY_MODE = 0,
  parameter int TIMEOUT       = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  bus_master_arbiter_if.master   bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  g_q, g_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        is_wr_q, is_wr_d;
  logic [7:0]  timer_q, timer_d;
  logic [3:0]  acc_q, acc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        srreq_q, srreq_d;
  logic        swreq_q, swreq_d;
  logic        tflag_q, tflag_d;
  logic [31:0] taddr_q, taddr_d;

  logic [3:0]  req;
  logic        win_found;
  logic [1:0]  win_idx;

  assign req = bus.master_rreq | bus.master_wreq;

  // Round-robin starts searching just after the last granted master.
  always_comb begin
    logic [1:0] cand;
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = (PRIORITY_MODE != 0) ? 2'(k) : 2'(last_grant_q + 2'(k + 1));
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    g_d          = g_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    is_wr_d      = is_wr_q;
    timer_d      = timer_q;
    acc_d        = 4'b0000;
    rdata_d      = rdata_q;
    err_d        = 1'b0;
    srreq_d      = 1'b0;
    swreq_d      = 1'b0;
    tflag_d      = tflag_q;
    taddr_d      = taddr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          g_d     = win_idx;
          addr_d  = bus.master_addr[{win_idx, 5'b00000} +: 32];
          wdata_d = bus.master_wdata[{win_idx, 5'b00000} +: 32];
          // A master raising both requests gets a write.
          is_wr_d = bus.master_wreq[win_idx];
          swreq_d = bus.master_wreq[win_idx];
          srreq_d = ~bus.master_wreq[win_idx];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + 8'd1;
        if (bus.slave_ack) begin
          if (!is_wr_q) rdata_d = bus.slave_rdata;
          acc_d   = 4'b0001 << g_q;
          state_d = ST_RELEASE;
        end else if (timer_q == TMO_LAST) begin
          acc_d   = 4'b0001 << g_q;
          err_d   = 1'b1;
          rdata_d = 32'hFFFF_FFFF;
          tflag_d = 1'b1;
          taddr_d = addr_q;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        last_grant_d = g_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      g_q          <= 2'd0;
      last_grant_q <= 2'd3;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      is_wr_q      <= 1'b0;
      timer_q      <= 8'd0;
      acc_q        <= 4'b0000;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
      srreq_q      <= 1'b0;
      swreq_q      <= 1'b0;
      tflag_q      <= 1'b0;
      taddr_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      g_q          <= g_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      is_wr_q      <= is_wr_d;
      timer_q      <= timer_d;
      acc_q        <= acc_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      srreq_q      <= srreq_d;
      swreq_q      <= swreq_d;
      tflag_q      <= tflag_d;
      taddr_q      <= taddr_d;
    end
  end

  assign bus.master_acc   = acc_q;
  assign bus.master_rdata = rdata_q;
  assign bus.master_err   = err_q;
  assign bus.master_busy  = (state_q != ST_IDLE);
  assign bus.slave_rreq   = srreq_q;
  assign bus.slave_wreq   = swreq_q;
  assign bus.slave_addr   = addr_q;
  assign bus.slave_wdata  = wdata_q;
  assign bus.timeout_flag = tflag_q;
  assign bus.timeout_addr = taddr_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance, both TIMEOUT=255.
module tb_bus_master_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bus_master_arbiter_if bus_rr ();
  bus_master_arbiter_if bus_fp ();

  bus_master_arbiter #(.PRIORITY_MODE(0), .TIMEOUT(255)) u_rr (
    .clk(clk), .reset(reset), .bus(bus_rr.master));
  bus_master_arbiter #(.PRIORITY_MODE(1), .TIMEOUT(255)) u_fp (
    .clk(clk), .reset(reset), .bus(bus_fp.master));

  // Waits for a strobe, acks in the following cycle, returns what the acc cycle shows.
  task automatic transact(input bit sel, input logic [31:0] rd, output logic [3:0] acc_seen,
                          output logic [31:0] addr_seen, output int acc_cyc);
    bit seen = 1'b0;
    acc_seen = 4'b0000; addr_seen = 32'd0; acc_cyc = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (sel ? (bus_fp.slave_rreq | bus_fp.slave_wreq) : (bus_rr.slave_rreq | bus_rr.slave_wreq))
        seen = 1'b1;
    end
    if (!seen) return;
    addr_seen = sel ? bus_fp.slave_addr : bus_rr.slave_addr;
    @(negedge clk);
    if (sel) begin bus_fp.slave_ack = 1'b1; bus_fp.slave_rdata = rd; end
    else     begin bus_rr.slave_ack = 1'b1; bus_rr.slave_rdata = rd; end
    @(negedge clk);
    bus_fp.slave_ack = 1'b0; bus_rr.slave_ack = 1'b0;
    acc_seen = sel ? bus_fp.master_acc : bus_rr.master_acc;
    acc_cyc  = cyc;
  endtask

  task automatic wait_strobe_rr(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus_rr.slave_rreq | bus_rr.slave_wreq) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_rr.master_rreq = '0; bus_rr.master_wreq = '0; bus_rr.master_addr = '0;
    bus_rr.master_wdata = '0; bus_rr.slave_rdata = '0; bus_rr.slave_ack = 1'b0;
    bus_fp.master_rreq = '0; bus_fp.master_wreq = '0; bus_fp.master_addr = '0;
    bus_fp.master_wdata = '0; bus_fp.slave_rdata = '0; bus_fp.slave_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_rr.master_acc, bus_rr.master_rdata, bus_rr.master_err, bus_rr.master_busy,
         bus_rr.slave_rreq, bus_rr.slave_wreq, bus_rr.slave_addr, bus_rr.slave_wdata,
         bus_rr.timeout_flag, bus_rr.timeout_addr} !== '0) begin
      errors++; $display("FAIL reset_rr_outputs got nonzero, required all 0");
    end
    checks++;
    if ({bus_fp.master_acc, bus_fp.master_rdata, bus_fp.master_err, bus_fp.master_busy,
         bus_fp.slave_rreq, bus_fp.slave_wreq, bus_fp.slave_addr, bus_fp.slave_wdata,
         bus_fp.timeout_flag, bus_fp.timeout_addr} !== '0) begin
      errors++; $display("FAIL reset_fp_outputs got nonzero, required all 0");
    end
    checks++;
    if (bus_rr.state_dbg !== 2'd0) begin
      errors++; $display("FAIL reset_state got %0d required 0", bus_rr.state_dbg);
    end
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_acc [5];
    logic [3:0]  acc;
    logic [31:0] addr;
    int          c, prev_c;
    exp_acc = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus_rr.master_addr = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    bus_rr.master_rreq = 4'b1111;
    prev_c = 0;
    for (int i = 0; i < 5; i++) begin
      transact(1'b0, 32'hD000_0000 + 32'(i), acc, addr, c);
      if (i == 4) bus_rr.master_rreq = 4'b0000;
      checks++;
      if (acc !== exp_acc[i]) begin
        errors++; $display("FAIL rr_order[%0d] got %b required %b", i, acc, exp_acc[i]);
      end
      checks++;
      if (bus_rr.master_rdata !== 32'hD000_0000 + 32'(i)) begin
        errors++; $display("FAIL rr_rdata[%0d] got %h required %h", i, bus_rr.master_rdata,
                           32'hD000_0000 + 32'(i));
      end
      if (i > 0) begin
        checks++;
        if (c - prev_c != 4) begin
          errors++; $display("FAIL rr_spacing[%0d] got %0d required 4", i, c - prev_c);
        end
      end
      prev_c = c;
    end
  endtask

  task automatic test_read_latency();
    @(negedge clk);
    bus_rr.master_addr[32 +: 32] = 32'h0000_8004;
    bus_rr.master_rreq = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus_rr.slave_rreq, bus_rr.slave_wreq} !== 2'b10 || bus_rr.slave_addr !== 32'h0000_8004) begin
      errors++; $display("FAIL lat_strobe got r%b w%b addr %h required r1 w0 addr 00008004",
                         bus_rr.slave_rreq, bus_rr.slave_wreq, bus_rr.slave_addr);
    end
    @(negedge clk);
    checks++;
    if (bus_rr.slave_rreq !== 1'b0 || bus_rr.master_busy !== 1'b1) begin
      errors++; $display("FAIL lat_wait got rreq %b busy %b required 0 1",
                         bus_rr.slave_rreq, bus_rr.master_busy);
    end
    bus_rr.slave_ack = 1'b1; bus_rr.slave_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_rr.slave_ack = 1'b0;
    checks++;
    if (bus_rr.master_acc !== 4'b0010 || bus_rr.master_rdata !== 32'hDEAD_BEEF || bus_rr.master_err !== 1'b0) begin
      errors++; $display("FAIL lat_acc got acc %b rdata %h err %b required 0010 deadbeef 0",
                         bus_rr.master_acc, bus_rr.master_rdata, bus_rr.master_err);
    end
    bus_rr.master_rreq = 4'b0000;
    @(negedge clk);
    checks++;
    if (bus_rr.master_acc !== 4'b0000 || bus_rr.master_busy !== 1'b0) begin
      errors++; $display("FAIL lat_idle got acc %b busy %b required 0000 0",
                         bus_rr.master_acc, bus_rr.master_busy);
    end
  endtask

  task automatic test_timeout();
    bit seen;
    int t0;
    bus_rr.master_addr[64 +: 32]  = 32'hC000_0000;
    bus_rr.master_wdata[64 +: 32] = 32'h1234_5678;
    bus_rr.master_wreq = 4'b0100;
    wait_strobe_rr(seen);
    checks++;
    if (!seen || bus_rr.slave_wreq !== 1'b1 || bus_rr.slave_wdata !== 32'h1234_5678) begin
      errors++; $display("FAIL to_strobe got seen %b wreq %b wdata %h required 1 1 12345678",
                         seen, bus_rr.slave_wreq, bus_rr.slave_wdata);
    end
    t0 = cyc;
    for (int i = 0; i < 300 && bus_rr.master_acc == 4'b0000; i++) @(negedge clk);
    checks++;
    if (bus_rr.master_acc !== 4'b0100 || bus_rr.master_err !== 1'b1) begin
      errors++; $display("FAIL to_acc got acc %b err %b required 0100 1",
                         bus_rr.master_acc, bus_rr.master_err);
    end
    checks++;
    if (cyc - t0 != 256) begin
      errors++; $display("FAIL to_latency got %0d required 256", cyc - t0);
    end
    checks++;
    if (bus_rr.master_rdata !== 32'hFFFF_FFFF || bus_rr.timeout_flag !== 1'b1 ||
        bus_rr.timeout_addr !== 32'hC000_0000) begin
      errors++; $display("FAIL to_status got rdata %h flag %b taddr %h required ffffffff 1 c0000000",
                         bus_rr.master_rdata, bus_rr.timeout_flag, bus_rr.timeout_addr);
    end
    bus_rr.master_wreq = 4'b0000;
    @(negedge clk);
    checks++;
    if (bus_rr.master_err !== 1'b0 || bus_rr.timeout_flag !== 1'b1) begin
      errors++; $display("FAIL to_after got err %b flag %b required 0 1",
                         bus_rr.master_err, bus_rr.timeout_flag);
    end
  endtask

  task automatic test_both_req();
    bit seen;
    bus_rr.master_addr[96 +: 32]  = 32'h4000_0010;
    bus_rr.master_wdata[96 +: 32] = 32'hA5A5_A5A5;
    bus_rr.master_rreq = 4'b1000;
    bus_rr.master_wreq = 4'b1000;
    wait_strobe_rr(seen);
    checks++;
    if (!seen || bus_rr.slave_wreq !== 1'b1 || bus_rr.slave_rreq !== 1'b0 ||
        bus_rr.slave_wdata !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL both_strobe got w%b r%b wdata %h required w1 r0 a5a5a5a5",
                         bus_rr.slave_wreq, bus_rr.slave_rreq, bus_rr.slave_wdata);
    end
    @(negedge clk);
    bus_rr.slave_ack = 1'b1; bus_rr.slave_rdata = 32'h1111_1111;
    @(negedge clk);
    bus_rr.slave_ack = 1'b0;
    checks++;
    if (bus_rr.master_acc !== 4'b1000 || bus_rr.master_rdata !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL both_acc got acc %b rdata %h required 1000 ffffffff",
                         bus_rr.master_acc, bus_rr.master_rdata);
    end
    bus_rr.master_rreq = 4'b0000;
    bus_rr.master_wreq = 4'b0000;
  endtask

  task automatic test_ack_at_timeout();
    bit seen;
    bus_rr.master_addr[0 +: 32] = 32'h0000_0050;
    bus_rr.master_rreq = 4'b0001;
    wait_strobe_rr(seen);
    for (int i = 0; i < 254; i++) @(negedge clk);
    @(negedge clk);
    bus_rr.slave_ack = 1'b1; bus_rr.slave_rdata = 32'h600D_F00D;
    @(negedge clk);
    bus_rr.slave_ack = 1'b0;
    checks++;
    if (!seen || bus_rr.master_acc !== 4'b0001 || bus_rr.master_err !== 1'b0 ||
        bus_rr.master_rdata !== 32'h600D_F00D) begin
      errors++; $display("FAIL ack_tmo got acc %b err %b rdata %h required 0001 0 600df00d",
                         bus_rr.master_acc, bus_rr.master_err, bus_rr.master_rdata);
    end
    bus_rr.master_rreq = 4'b0000;
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    logic [3:0]  acc;
    logic [31:0] addr;
    int          c;
    @(negedge clk);
    bus_rr.master_addr[32 +: 32] = 32'h7000_0000;
    bus_rr.master_rreq = 4'b0010;
    wait_strobe_rr(seen);
    @(negedge clk);
    checks++;
    if (!seen || bus_rr.state_dbg !== 2'd2) begin
      errors++; $display("FAIL rst_pre got state %0d required 2", bus_rr.state_dbg);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus_rr.master_acc, bus_rr.master_rdata, bus_rr.master_err, bus_rr.master_busy,
         bus_rr.slave_rreq, bus_rr.slave_wreq, bus_rr.slave_addr, bus_rr.slave_wdata} !== '0) begin
      errors++; $display("FAIL rst_async_bus got acc %b rdata %h busy %b addr %h required all 0",
                         bus_rr.master_acc, bus_rr.master_rdata, bus_rr.master_busy, bus_rr.slave_addr);
    end
    checks++;
    if (bus_rr.timeout_flag !== 1'b0 || bus_rr.timeout_addr !== 32'd0) begin
      errors++; $display("FAIL rst_async_tmo got flag %b taddr %h required 0 0",
                         bus_rr.timeout_flag, bus_rr.timeout_addr);
    end
    bus_rr.master_rreq = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    bus_rr.master_addr = {32'h0, 32'h0000_2200, 32'h0, 32'h0000_0100};
    bus_rr.master_rreq = 4'b0101;
    transact(1'b0, 32'h0000_0ABC, acc, addr, c);
    bus_rr.master_rreq = 4'b0000;
    checks++;
    if (acc !== 4'b0001 || addr !== 32'h0000_0100) begin
      errors++; $display("FAIL rst_first_grant got acc %b addr %h required 0001 00000100", acc, addr);
    end
    checks++;
    if (bus_rr.timeout_flag !== 1'b0) begin
      errors++; $display("FAIL rst_flag got %b required 0", bus_rr.timeout_flag);
    end
  endtask

  task automatic test_fixed_priority();
    logic [3:0]  acc;
    logic [31:0] addr;
    int          c;
    bus_fp.master_addr = {32'h3300_0000, 32'h2200_0000, 32'h1100_0000, 32'h0000_0C00};
    bus_fp.master_rreq = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      transact(1'b1, 32'hF000_0000 + 32'(i), acc, addr, c);
      if (i == 2) bus_fp.master_rreq = 4'b1110;
      checks++;
      if (acc !== 4'b0001 || addr !== 32'h0000_0C00) begin
        errors++; $display("FAIL fp_m0[%0d] got acc %b addr %h required 0001 00000c00", i, acc, addr);
      end
    end
    transact(1'b1, 32'hF000_0010, acc, addr, c);
    bus_fp.master_rreq = 4'b0000;
    checks++;
    if (acc !== 4'b0010 || addr !== 32'h1100_0000 || bus_fp.master_rdata !== 32'hF000_0010) begin
      errors++; $display("FAIL fp_m1 got acc %b addr %h rdata %h required 0010 11000000 f0000010",
                         acc, addr, bus_fp.master_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_read_latency();
    test_timeout();
    test_both_req();
    test_ack_at_timeout();
    test_reset_mid_wait();
    test_fixed_priority();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
